rs_dispatch_arbiter: RTL and testbench
======================================

Name: rs_dispatch_arbiter

Overview:
- Selects one ready add/sub reservation station per dispatch opportunity and launches the shared add/sub arithmetic unit (UA).
- Sits between the ASRS stations and the UA.
- Selection is oldest-first, using the 10-bit issue counter stamped into each station, with wrap-safe comparison.
- Owns the UA start handshake and tells the winning station it was granted.

Parameters:
- N_RS, 4, number of reservation stations arbitrated.
- W_DATA, 16, operand width.
- W_OP, 3, operation code width.
- W_TAG, 3, station ID / CDB tag width.
- W_AGE, 10, issue counter width.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- cur_count  in  W_AGE  current issue counter value.
- rs_ready  in  N_RS  per-station "operands ready, wants dispatch".
- rs_age  in  N_RS*W_AGE  per-station issue stamp; station i occupies slice i.
- rs_val1  in  N_RS*W_DATA  per-station operand 1.
- rs_val2  in  N_RS*W_DATA  per-station operand 2.
- rs_op  in  N_RS*W_OP  per-station opcode.
- rs_tag  in  N_RS*W_TAG  per-station ID.
- rs_grant  out  N_RS  one-hot, one-cycle pulse to the winning station.
- fu_busy  in  1  UA busy.
- fu_done  in  1  UA result-confirm pulse.
- fu_start  out  1  one-cycle UA start pulse.
- fu_a  out  W_DATA  operand 1 to the UA.
- fu_b  out  W_DATA  operand 2 to the UA.
- fu_op  out  W_OP  opcode to the UA.
- fu_tag  out  W_TAG  tag to the UA.

Behaviour:
- Reset (CLR=0, asynchronous):
  - state=IDLE.
  - rs_grant, fu_start, fu_a, fu_b, fu_op, fu_tag all 0.
  - Grant mask cleared.
  - Reset during WAIT abandons the operation; no start or grant is reissued after release.
- Age:
  - age_i = (cur_count - rs_age_i) mod 2^W_AGE.
  - Larger age is older; age 0 is valid.
  - Ties go to the lowest index.
- Eligible set: rs_ready & ~mask.
  - mask holds the one-hot of the last grant for exactly one cycle after the grant, covering the station's clear latency; otherwise it is 0.
- FSM, IDLE:
  - If eligible != 0 and fu_busy=0 at edge k, the following are registered at edge k and valid for the cycle after:
    - fu_start=1;
    - rs_grant=onehot(winner);
    - fu_a/fu_b/fu_op/fu_tag = winner's fields.
  - Then go to WAIT.
  - Otherwise remain in IDLE with start and grant at 0.
- FSM, WAIT:
  - fu_start and rs_grant return to 0 after one cycle.
  - fu_a/fu_b/fu_op/fu_tag hold their values.
  - fu_busy is ignored.
  - On fu_done=1:
    - if eligible != 0, dispatch the next winner at the same edge (back-to-back) and stay in WAIT;
    - otherwise go to IDLE.
  - fu_done in IDLE is ignored.
- Latency: one cycle from sampled ready to fu_start.
- Throughput: one dispatch per UA completion.
- Exactly one rs_grant bit is ever high at a time, and it is high only together with fu_start.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- When defined, adds two outputs, each 16 bits, saturating at 0xFFFF, cleared by reset:
  - stat_issued: increments on each fu_start.
  - stat_stall: increments each cycle with eligible != 0 and no dispatch.
- When not defined, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - width constants (W_DATA, W_OP, W_TAG, W_AGE);
  - the FSM state encoding IDLE=0, WAIT=1.
- One natural sub-module: age_picker. It is combinational and takes eligible plus the ages and returns the one-hot winner and its index.

Test Plan:
- Single dispatch: cur_count=5; rs_ready=0001, age0=3; fu_busy=0 → next cycle fu_start=1, rs_grant=0001, fu_a/fu_b/fu_op/fu_tag equal station 0's fields.
- Oldest wins: cur_count=20; ready=1111, ages 18,12,15,19 → grant=0010. After fu_done with ready=1101 → grant=0100.
- Wrap: cur_count=2; ready=0011, age0=1020, age1=1 → grant=0001 (age 6 vs 1).
- Tie and mask: ages equal, ready=1100 → grant=0100. One cycle later fu_done=1 while rs_ready[2] is still 1 → grant=1000.
- Busy and reset: fu_busy=1 with ready=0001 → no start. Drop fu_busy → start. Assert CLR in WAIT → all outputs 0, state IDLE.
- DISPATCH_STATS_EN: 3 dispatches plus 4 blocked cycles → stat_issued=3, stat_stall=4.

Source files
------------

// File: rtl/rs_dispatch_arbiter_pkg.sv
// Shared definitions for the add/sub reservation-station dispatch arbiter.
// Holds the datapath width constants, the dispatch FSM state encoding and
// the packed payload that is launched into the add/sub unit (UA).
package rs_dispatch_arbiter_pkg;

   localparam int unsigned W_DATA = 16;
   localparam int unsigned W_OP   = 3;
   localparam int unsigned W_TAG  = 3;
   localparam int unsigned W_AGE  = 10;
   localparam int unsigned W_STAT = 16;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } disp_state_t;

   // Operands, opcode and tag handed to the UA on a dispatch.
   typedef struct packed {
      logic [W_DATA-1:0] a;
      logic [W_DATA-1:0] b;
      logic [W_OP-1:0]   op;
      logic [W_TAG-1:0]  tag;
   } fu_payload_t;

endpackage

// File: rtl/rs_dispatch_arbiter_age_picker.sv
// Combinational oldest-first picker.
// Ports:
//   eligible   in  N_RS        stations allowed to compete this cycle
//   ages       in  N_RS*W_AGE  per-station age (already wrap-corrected)
//   win_oh_c   out N_RS        one-hot winner (0 when nothing eligible)
//   win_idx_c  out W_IDX       winner index
//   any_c      out 1           at least one station eligible
// Larger age wins; ties resolve to the lowest index.
module rs_dispatch_arbiter_age_picker
   import rs_dispatch_arbiter_pkg::*;
#(
   parameter int unsigned N_RS  = 4,
   parameter int unsigned W_IDX = $clog2(N_RS)
) (
   input  logic [N_RS-1:0]       eligible,
   input  logic [N_RS*W_AGE-1:0] ages,
   output logic [N_RS-1:0]       win_oh_c,
   output logic [W_IDX-1:0]      win_idx_c,
   output logic                  any_c
);

   logic [W_AGE-1:0] best_age;

   // Strictly-greater compare keeps the earliest index on ties.
   always_comb begin
      win_oh_c  = '0;
      win_idx_c = '0;
      any_c     = 1'b0;
      best_age  = '0;
      for (int i = 0; i < N_RS; i++) begin
         if (eligible[i] && (!any_c || (ages[i*W_AGE +: W_AGE] > best_age))) begin
            any_c     = 1'b1;
            best_age  = ages[i*W_AGE +: W_AGE];
            win_idx_c = W_IDX'(i);
         end
      end
      win_oh_c[win_idx_c] = any_c;
   end

endmodule

// File: rtl/rs_dispatch_arbiter.sv
// Dispatch arbiter between the add/sub reservation stations and the shared
// add/sub unit (UA). Picks the oldest ready station, pulses fu_start and the
// winner's rs_grant for one cycle, and holds the operands until the next
// dispatch. A new dispatch happens from IDLE when the UA is not busy, or
// back-to-back from WAIT on the UA's fu_done pulse.
// Ports:
//   CLK, CLR                 clock (rising), async active-low reset
//   cur_count                current issue counter
//   rs_ready/age/val1/val2/op/tag   flattened per-station request fields
//   rs_grant                 one-hot grant pulse to the winning station
//   fu_busy, fu_done         UA status / result-confirm pulse
//   fu_start, fu_a, fu_b, fu_op, fu_tag   UA launch interface
// Optional (macro DISPATCH_STATS_EN):
//   stat_issued, stat_stall  saturating dispatch / stall counters
module rs_dispatch_arbiter
   import rs_dispatch_arbiter_pkg::*;
#(
   parameter int unsigned N_RS = 4
) (
   input  logic                   CLK,
   input  logic                   CLR,
   input  logic [W_AGE-1:0]       cur_count,
   input  logic [N_RS-1:0]        rs_ready,
   input  logic [N_RS*W_AGE-1:0]  rs_age,
   input  logic [N_RS*W_DATA-1:0] rs_val1,
   input  logic [N_RS*W_DATA-1:0] rs_val2,
   input  logic [N_RS*W_OP-1:0]   rs_op,
   input  logic [N_RS*W_TAG-1:0]  rs_tag,
   output logic [N_RS-1:0]        rs_grant,
   input  logic                   fu_busy,
   input  logic                   fu_done,
   output logic                   fu_start,
   output logic [W_DATA-1:0]      fu_a,
   output logic [W_DATA-1:0]      fu_b,
   output logic [W_OP-1:0]        fu_op,
`ifdef DISPATCH_STATS_EN
   output logic [W_TAG-1:0]       fu_tag,
   output logic [W_STAT-1:0]      stat_issued,
   output logic [W_STAT-1:0]      stat_stall
`else
   output logic [W_TAG-1:0]       fu_tag
`endif
);

   localparam int unsigned W_IDX = $clog2(N_RS);

   disp_state_t          state_q, state_d;
   logic [N_RS-1:0]      mask_q;
   logic [N_RS-1:0]      eligible_c;
   logic [N_RS*W_AGE-1:0] ages_c;
   logic [N_RS-1:0]      win_oh_c;
   logic [W_IDX-1:0]     win_idx_c;
   logic                 any_c;
   logic                 dispatch_c;
   fu_payload_t          win_pl_c;
   fu_payload_t          pl_q;

   // The just-granted station still shows ready while it clears; keep it out.
   assign eligible_c = rs_ready & ~mask_q;

   // Modular subtraction makes the age comparison safe across counter wrap.
   always_comb begin
      ages_c = '0;
      for (int i = 0; i < N_RS; i++) begin
         ages_c[i*W_AGE +: W_AGE] = cur_count - rs_age[i*W_AGE +: W_AGE];
      end
   end

   rs_dispatch_arbiter_age_picker #(
      .N_RS  (N_RS),
      .W_IDX (W_IDX)
   ) u_age_picker (
      .eligible  (eligible_c),
      .ages      (ages_c),
      .win_oh_c  (win_oh_c),
      .win_idx_c (win_idx_c),
      .any_c     (any_c)
   );

   // Winner's fields muxed out of the flattened station buses.
   always_comb begin
      win_pl_c.a   = rs_val1[win_idx_c*W_DATA +: W_DATA];
      win_pl_c.b   = rs_val2[win_idx_c*W_DATA +: W_DATA];
      win_pl_c.op  = rs_op[win_idx_c*W_OP +: W_OP];
      win_pl_c.tag = rs_tag[win_idx_c*W_TAG +: W_TAG];
   end

   // State register.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state and dispatch decision.
   always_comb begin
      state_d    = state_q;
      dispatch_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_c && !fu_busy) begin
               dispatch_c = 1'b1;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (fu_done) begin
               if (any_c) dispatch_c = 1'b1;
               else       state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered launch interface; payload holds between dispatches.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         fu_start <= 1'b0;
         rs_grant <= '0;
         mask_q   <= '0;
         pl_q     <= '0;
      end else begin
         fu_start <= dispatch_c;
         rs_grant <= dispatch_c ? win_oh_c : '0;
         mask_q   <= dispatch_c ? win_oh_c : '0;
         if (dispatch_c) pl_q <= win_pl_c;
      end
   end

   assign fu_a   = pl_q.a;
   assign fu_b   = pl_q.b;
   assign fu_op  = pl_q.op;
   assign fu_tag = pl_q.tag;

`ifdef DISPATCH_STATS_EN
   // Saturating counters: dispatches, and cycles with demand but no dispatch.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (dispatch_c && (stat_issued != '1))
            stat_issued <= stat_issued + W_STAT'(1);
         if (any_c && !dispatch_c && (stat_stall != '1))
            stat_stall <= stat_stall + W_STAT'(1);
      end
   end
`endif

endmodule

// File: tb/tb_rs_dispatch_arbiter.sv
// Directed bench for rs_dispatch_arbiter with hand-computed expectations.
module tb_rs_dispatch_arbiter;
   import rs_dispatch_arbiter_pkg::*;

   localparam int unsigned N = 4;

   logic                 CLK = 1'b0;
   logic                 CLR;
   logic [W_AGE-1:0]     cur_count;
   logic [N-1:0]         rs_ready;
   logic [N*W_AGE-1:0]   rs_age;
   logic [N*W_DATA-1:0]  rs_val1;
   logic [N*W_DATA-1:0]  rs_val2;
   logic [N*W_OP-1:0]    rs_op;
   logic [N*W_TAG-1:0]   rs_tag;
   logic [N-1:0]         rs_grant;
   logic                 fu_busy;
   logic                 fu_done;
   logic                 fu_start;
   logic [W_DATA-1:0]    fu_a;
   logic [W_DATA-1:0]    fu_b;
   logic [W_OP-1:0]      fu_op;
   logic [W_TAG-1:0]     fu_tag;
`ifdef DISPATCH_STATS_EN
   logic [15:0]          stat_issued;
   logic [15:0]          stat_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rs_dispatch_arbiter #(.N_RS(N)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .cur_count (cur_count),
      .rs_ready  (rs_ready),
      .rs_age    (rs_age),
      .rs_val1   (rs_val1),
      .rs_val2   (rs_val2),
      .rs_op     (rs_op),
      .rs_tag    (rs_tag),
      .rs_grant  (rs_grant),
      .fu_busy   (fu_busy),
      .fu_done   (fu_done),
      .fu_start  (fu_start),
      .fu_a      (fu_a),
      .fu_b      (fu_b),
      .fu_op     (fu_op),
`ifdef DISPATCH_STATS_EN
      .fu_tag      (fu_tag),
      .stat_issued (stat_issued),
      .stat_stall  (stat_stall)
`else
      .fu_tag    (fu_tag)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_rs(input int i, input logic [W_AGE-1:0] age,
                         input logic [W_DATA-1:0] v1, input logic [W_DATA-1:0] v2,
                         input logic [W_OP-1:0] op, input logic [W_TAG-1:0] tg);
      rs_age[i*W_AGE +: W_AGE]    = age;
      rs_val1[i*W_DATA +: W_DATA] = v1;
      rs_val2[i*W_DATA +: W_DATA] = v2;
      rs_op[i*W_OP +: W_OP]       = op;
      rs_tag[i*W_TAG +: W_TAG]    = tg;
   endtask

   task automatic set_age(input int i, input logic [W_AGE-1:0] age);
      rs_age[i*W_AGE +: W_AGE] = age;
   endtask

   initial begin
      CLR       = 1'b0;
      cur_count = '0;
      rs_ready  = '0;
      rs_age    = '0;
      rs_val1   = '0;
      rs_val2   = '0;
      rs_op     = '0;
      rs_tag    = '0;
      fu_busy   = 1'b0;
      fu_done   = 1'b0;
      set_rs(0, 10'd3, 16'h1111, 16'h2222, 3'd1, 3'd0);
      set_rs(1, 10'd0, 16'h3333, 16'h4444, 3'd2, 3'd1);
      set_rs(2, 10'd0, 16'h5555, 16'h6666, 3'd3, 3'd2);
      set_rs(3, 10'd0, 16'h7777, 16'h8888, 3'd4, 3'd3);

      // Reset values
      step();
      chk("rst_start", 32'(fu_start), 32'd0);
      chk("rst_grant", 32'(rs_grant), 32'd0);
      chk("rst_a",     32'(fu_a),     32'd0);
      chk("rst_tag",   32'(fu_tag),   32'd0);
      CLR = 1'b1;
      step();

      // Single dispatch: station 0
      cur_count = 10'd5;
      rs_ready  = 4'b0001;
      step();
      chk("single_start", 32'(fu_start), 32'd1);
      chk("single_grant", 32'(rs_grant), 32'b0001);
      chk("single_a",     32'(fu_a),     32'h1111);
      chk("single_b",     32'(fu_b),     32'h2222);
      chk("single_op",    32'(fu_op),    32'd1);
      chk("single_tag",   32'(fu_tag),   32'd0);
      rs_ready = 4'b0000;
      step();
      chk("single_pulse_start", 32'(fu_start), 32'd0);
      chk("single_pulse_grant", 32'(rs_grant), 32'd0);
      chk("single_hold_a",      32'(fu_a),     32'h1111);
      fu_done = 1'b1;
      step();
      fu_done = 1'b0;
      chk("single_done_idle", 32'(fu_start), 32'd0);

      // Oldest wins: ages 2,8,5,1
      cur_count = 10'd20;
      set_age(0, 10'd18); set_age(1, 10'd12); set_age(2, 10'd15); set_age(3, 10'd19);
      rs_ready = 4'b1111;
      step();
      chk("oldest_grant", 32'(rs_grant), 32'b0010);
      chk("oldest_a",     32'(fu_a),     32'h3333);
      chk("oldest_tag",   32'(fu_tag),   32'd1);
      rs_ready = 4'b1101;
      step();
      chk("oldest_wait_start", 32'(fu_start), 32'd0);
      step();
      chk("busy_ignored_in_wait", 32'(fu_start), 32'd0);
      fu_done = 1'b1;
      step();
      chk("b2b_start", 32'(fu_start), 32'd1);
      chk("b2b_grant", 32'(rs_grant), 32'b0100);
      chk("b2b_b",     32'(fu_b),     32'h6666);
      fu_done  = 1'b0;
      rs_ready = 4'b0000;
      step();
      fu_done = 1'b1;
      step();
      fu_done = 1'b0;
      chk("b2b_to_idle", 32'(fu_start), 32'd0);
      step();

      // Wrap: age0 = (2-1020) mod 1024 = 6, age1 = 1
      cur_count = 10'd2;
      set_age(0, 10'd1020); set_age(1, 10'd1);
      rs_ready = 4'b0011;
      step();
      chk("wrap_grant", 32'(rs_grant), 32'b0001);
      chk("wrap_a",     32'(fu_a),     32'h1111);
      rs_ready = 4'b0000;
      step();
      fu_done = 1'b1;
      step();
      fu_done = 1'b0;
      step();

      // Tie then mask
      cur_count = 10'd100;
      set_age(2, 10'd100); set_age(3, 10'd100);
      rs_ready = 4'b1100;
      step();
      chk("tie_grant", 32'(rs_grant), 32'b0100);
      chk("tie_tag",   32'(fu_tag),   32'd2);
      fu_done = 1'b1;
      step();
      chk("mask_grant", 32'(rs_grant), 32'b1000);
      chk("mask_tag",   32'(fu_tag),   32'd3);
      chk("mask_b",     32'(fu_b),     32'h8888);
      fu_done  = 1'b0;
      rs_ready = 4'b0000;
      step();
      fu_done = 1'b1;
      step();
      fu_done = 1'b0;
      step();
      chk("done_in_idle_ignored", 32'(fu_start), 32'd0);

      // Busy blocks, release dispatches, reset in WAIT
      cur_count = 10'd5;
      set_age(0, 10'd3);
      fu_busy  = 1'b1;
      rs_ready = 4'b0001;
      step();
      chk("busy_block1", 32'(fu_start), 32'd0);
      step();
      chk("busy_block2", 32'(rs_grant), 32'd0);
      fu_busy = 1'b0;
      step();
      chk("busy_release_start", 32'(fu_start), 32'd1);
      chk("busy_release_grant", 32'(rs_grant), 32'b0001);
      rs_ready = 4'b0000;
      step();
      CLR = 1'b0;
      #1;
      chk("clr_wait_start", 32'(fu_start), 32'd0);
      chk("clr_wait_a",     32'(fu_a),     32'd0);
      chk("clr_wait_op",    32'(fu_op),    32'd0);
      step();
      CLR = 1'b1;
      step();
      chk("post_clr_no_start", 32'(fu_start), 32'd0);
      chk("post_clr_no_grant", 32'(rs_grant), 32'd0);
      rs_ready = 4'b0001;
      step();
      chk("post_clr_idle_dispatch", 32'(fu_start), 32'd1);
      rs_ready = 4'b0000;
      step();
      fu_done = 1'b1;
      step();
      fu_done = 1'b0;

`ifdef DISPATCH_STATS_EN
      // Stats: 4 blocked cycles then 3 dispatches
      CLR = 1'b0;
      step();
      CLR = 1'b1;
      fu_busy  = 1'b1;
      rs_ready = 4'b0001;
      step(); step(); step(); step();
      fu_busy = 1'b0;
      step();
      rs_ready = 4'b0000;
      step();
      rs_ready = 4'b0001;
      fu_done  = 1'b1;
      step();
      rs_ready = 4'b0000;
      fu_done  = 1'b0;
      step();
      rs_ready = 4'b0001;
      fu_done  = 1'b1;
      step();
      rs_ready = 4'b0000;
      step();
      fu_done = 1'b0;
      step();
      chk("stat_issued", 32'(stat_issued), 32'd3);
      chk("stat_stall",  32'(stat_stall),  32'd4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
